id_ex_operand_stage: RTL

ID_EX_OPERAND_STAGE -- requirements
Module: id_ex_operand_stage

---
 rtl/id_ex_operand_stage_pkg.sv | 24 ++
 rtl/id_ex_operand_stage_if.sv | 60 ++++++
 rtl/id_ex_operand_stage_forward_mux.sv | 38 +++
 rtl/id_ex_operand_stage.sv | 113 +++++++++++
 4 files changed

// File: rtl/id_ex_operand_stage_pkg.sv
// Shared definitions for the ID/EX operand stage: ALU opcodes and the
// forwarding-source encoding used by the operand muxes.
package id_ex_operand_stage_pkg;

    typedef enum logic [3:0] {
        ALU_BUBBLE  = 4'd0,
        ALU_SUB     = 4'd1,
        ALU_OR      = 4'd2,
        ALU_ADD     = 4'd3,
        ALU_LUI     = 4'd4,
        ALU_SLL     = 4'd5,
        ALU_SRL     = 4'd6,
        ALU_AND     = 4'd7,
        ALU_NOR     = 4'd8,
        ALU_NOTHING = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_MEMWB = 2'd1,
        FWD_EXMEM = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Decode-side, bypass and ALU-side signals of the ID/EX operand stage.
// The stage itself uses the slave modport; the driver of decode uses master.
interface id_ex_operand_stage_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      stall_i;
    logic                      flush_i;
    logic                      id_valid_i;
    logic [3:0]                id_alu_operation_i;
    logic [DATA_WIDTH-1:0]     id_rs_data_i;
    logic [DATA_WIDTH-1:0]     id_rt_data_i;
    logic [DATA_WIDTH-1:0]     id_imm_i;
    logic [4:0]                id_shamt_i;
    logic [REG_ADDR_WIDTH-1:0] id_rs_addr_i;
    logic [REG_ADDR_WIDTH-1:0] id_rt_addr_i;
    logic [REG_ADDR_WIDTH-1:0] id_rd_addr_i;
    logic                      id_alu_src_i;
    logic                      id_reg_write_i;
    logic                      id_mem_read_i;
    logic                      exmem_reg_write_i;
    logic                      memwb_reg_write_i;
    logic [REG_ADDR_WIDTH-1:0] exmem_rd_addr_i;
    logic [REG_ADDR_WIDTH-1:0] memwb_rd_addr_i;
    logic [DATA_WIDTH-1:0]     exmem_data_i;
    logic [DATA_WIDTH-1:0]     memwb_data_i;

    logic [3:0]                alu_operation_o;
    logic [DATA_WIDTH-1:0]     a_o;
    logic [DATA_WIDTH-1:0]     b_o;
    logic [4:0]                shamt_o;
    logic [DATA_WIDTH-1:0]     rt_data_o;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_o;
    logic                      reg_write_o;
    logic                      mem_read_o;
    logic                      valid_o;
    logic                      hazard_stall_o;

    modport master (
        output stall_i, flush_i, id_valid_i, id_alu_operation_i,
               id_rs_data_i, id_rt_data_i, id_imm_i, id_shamt_i,
               id_rs_addr_i, id_rt_addr_i, id_rd_addr_i,
               id_alu_src_i, id_reg_write_i, id_mem_read_i,
               exmem_reg_write_i, memwb_reg_write_i,
               exmem_rd_addr_i, memwb_rd_addr_i, exmem_data_i, memwb_data_i,
        input  alu_operation_o, a_o, b_o, shamt_o, rt_data_o, rd_addr_o,
               reg_write_o, mem_read_o, valid_o, hazard_stall_o
    );

    modport slave (
        input  stall_i, flush_i, id_valid_i, id_alu_operation_i,
               id_rs_data_i, id_rt_data_i, id_imm_i, id_shamt_i,
               id_rs_addr_i, id_rt_addr_i, id_rd_addr_i,
               id_alu_src_i, id_reg_write_i, id_mem_read_i,
               exmem_reg_write_i, memwb_reg_write_i,
               exmem_rd_addr_i, memwb_rd_addr_i, exmem_data_i, memwb_data_i,
        output alu_operation_o, a_o, b_o, shamt_o, rt_data_o, rd_addr_o,
               reg_write_o, mem_read_o, valid_o, hazard_stall_o
    );
endinterface

// File: rtl/id_ex_operand_stage_forward_mux.sv
// Selects one source operand from EX/MEM, MEM/WB or the registered value;
// the youngest producer wins and register 0 is never bypassed.
module forward_mux
    import id_ex_operand_stage_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] src_addr,
    input  logic [DATA_WIDTH-1:0]     reg_data,
    input  logic                      exmem_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_rd_addr,
    input  logic [DATA_WIDTH-1:0]     exmem_data,
    input  logic                      memwb_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_rd_addr,
    input  logic [DATA_WIDTH-1:0]     memwb_data,
    output logic [DATA_WIDTH-1:0]     data
);
    fwd_sel_e sel;

    // NOTE: defaults assigned first so every path drives sel/data (no latch).
    always_comb begin
        sel = FWD_REG;
        if (memwb_reg_write && memwb_rd_addr != '0 && memwb_rd_addr == src_addr)
            sel = FWD_MEMWB;
        if (exmem_reg_write && exmem_rd_addr != '0 && exmem_rd_addr == src_addr)
            sel = FWD_EXMEM;
    end

    always_comb begin
        data = reg_data;
        case (sel)
            FWD_EXMEM: data = exmem_data;
            FWD_MEMWB: data = memwb_data;
            default:   data = reg_data;
        endcase
    end
endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with load-use hazard detection and operand
// forwarding applied on the register outputs.
module id_ex_operand_stage
    import id_ex_operand_stage_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                clk,
    input  logic                reset,
    id_ex_operand_stage_if.slave bus
);
    typedef struct packed {
        logic                      valid;
        logic [3:0]                alu_op;
        logic [DATA_WIDTH-1:0]     rs_data;
        logic [DATA_WIDTH-1:0]     rt_data;
        logic [DATA_WIDTH-1:0]     imm;
        logic [4:0]                shamt;
        logic [REG_ADDR_WIDTH-1:0] rs_addr;
        logic [REG_ADDR_WIDTH-1:0] rt_addr;
        logic [REG_ADDR_WIDTH-1:0] rd_addr;
        logic                      alu_src;
        logic                      reg_write;
        logic                      mem_read;
    } stage_t;

    // An all-zero register is the bubble; ALU_BUBBLE encodes as 0.
    localparam stage_t BUBBLE = '0;

    stage_t stage_q;
    stage_t stage_d;
    logic   hazard;

    always_comb begin
        hazard = 1'b0;
        if (!reset && bus.id_valid_i && stage_q.valid && stage_q.mem_read &&
            stage_q.rd_addr != '0) begin
            hazard = (stage_q.rd_addr == bus.id_rs_addr_i) ||
                     (!bus.id_alu_src_i && stage_q.rd_addr == bus.id_rt_addr_i);
        end
    end

    always_comb begin
        stage_d           = BUBBLE;
        stage_d.valid     = bus.id_valid_i;
        stage_d.alu_op    = bus.id_alu_operation_i;
        stage_d.rs_data   = bus.id_rs_data_i;
        stage_d.rt_data   = bus.id_rt_data_i;
        stage_d.imm       = bus.id_imm_i;
        stage_d.shamt     = bus.id_shamt_i;
        stage_d.rs_addr   = bus.id_rs_addr_i;
        stage_d.rt_addr   = bus.id_rt_addr_i;
        stage_d.rd_addr   = bus.id_rd_addr_i;
        stage_d.alu_src   = bus.id_alu_src_i;
        stage_d.reg_write = bus.id_reg_write_i;
        stage_d.mem_read  = bus.id_mem_read_i;
    end

    // A downstream stall keeps the load in EX, so the hazard bubble only
    // goes in when the stage is actually advancing.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stage_q <= BUBBLE;
        else if (bus.flush_i)
            stage_q <= BUBBLE;
        else if (!bus.stall_i) begin
            if (hazard)
                stage_q <= BUBBLE;
            else
                stage_q <= stage_d;
        end
    end

    logic [DATA_WIDTH-1:0] rs_fwd;
    logic [DATA_WIDTH-1:0] rt_fwd;

    forward_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_rs (
        .src_addr        (stage_q.rs_addr),
        .reg_data        (stage_q.rs_data),
        .exmem_reg_write (bus.exmem_reg_write_i),
        .exmem_rd_addr   (bus.exmem_rd_addr_i),
        .exmem_data      (bus.exmem_data_i),
        .memwb_reg_write (bus.memwb_reg_write_i),
        .memwb_rd_addr   (bus.memwb_rd_addr_i),
        .memwb_data      (bus.memwb_data_i),
        .data            (rs_fwd)
    );

    forward_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_rt (
        .src_addr        (stage_q.rt_addr),
        .reg_data        (stage_q.rt_data),
        .exmem_reg_write (bus.exmem_reg_write_i),
        .exmem_rd_addr   (bus.exmem_rd_addr_i),
        .exmem_data      (bus.exmem_data_i),
        .memwb_reg_write (bus.memwb_reg_write_i),
        .memwb_rd_addr   (bus.memwb_rd_addr_i),
        .memwb_data      (bus.memwb_data_i),
        .data            (rt_fwd)
    );

    assign bus.a_o             = rs_fwd;
    assign bus.b_o             = stage_q.alu_src ? stage_q.imm : rt_fwd;
    assign bus.rt_data_o       = rt_fwd;
    assign bus.alu_operation_o = stage_q.alu_op;
    assign bus.shamt_o         = stage_q.shamt;
    assign bus.rd_addr_o       = stage_q.rd_addr;
    assign bus.reg_write_o     = stage_q.reg_write;
    assign bus.mem_read_o      = stage_q.mem_read;
    assign bus.valid_o         = stage_q.valid;
    assign bus.hazard_stall_o  = hazard;
endmodule
